// File: rtl/rdma_pkg.sv
// ---------------------------------------------------------------------------
// rdma_pkg
// Shared definitions for the RDMA header path: header field byte offsets,
// the header-insert state encoding and a byte-enable popcount helper.
// No ports (package).
// ---------------------------------------------------------------------------
package rdma_pkg;

   // Header field byte offsets within the header beat (little-endian)
   localparam int ADDR_OFS = 0;
   localparam int LEN_OFS  = 8;
   localparam int SEQ_OFS  = 12;
   localparam int USER_OFS = 16;

   // popcount input width; covers streams up to 128 bytes wide
   localparam int POPC_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   function automatic logic [31:0] popcount(input logic [POPC_W-1:0] v);
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < POPC_W; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/rdma_hdr_insert.sv
// ---------------------------------------------------------------------------
// rdma_hdr_insert
// Places an RDMA header beat (addr, len, sequence number, user bytes) in
// front of each payload AXI-Stream packet, then forwards the payload with
// no added latency. Counts payload bytes and flags a mismatch against the
// commanded length.
//
// Ports
//   clk, resetn                      clock, synchronous active-low reset
//   CMD_ADDR/LEN/USER/VALID, READY   per-packet command
//   AXIS_RX_*                        payload stream in
//   AXIS_TX_*                        header beat + payload stream out
//   SEQ_NUM                          sequence number the next header carries
//   LEN_ERR                          one-cycle pulse on length mismatch
//   LEN_ERR_COUNT                    saturating mismatch count
// ---------------------------------------------------------------------------
module rdma_hdr_insert
   import rdma_pkg::*;
#(
   parameter  int STREAM_WB    = 64,
   parameter  int RDMA_HDR_LEN = 50,
   localparam int USER_WB      = RDMA_HDR_LEN - 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [63:0]            CMD_ADDR,
   input  logic [31:0]            CMD_LEN,
   input  logic [USER_WB*8-1:0]   CMD_USER,
   input  logic                   CMD_VALID,
   output logic                   CMD_READY,
   input  logic [STREAM_WB*8-1:0] AXIS_RX_TDATA,
   input  logic [STREAM_WB-1:0]   AXIS_RX_TKEEP,
   input  logic                   AXIS_RX_TVALID,
   input  logic                   AXIS_RX_TLAST,
   output logic                   AXIS_RX_TREADY,
   output logic [STREAM_WB*8-1:0] AXIS_TX_TDATA,
   output logic [STREAM_WB-1:0]   AXIS_TX_TKEEP,
   output logic                   AXIS_TX_TVALID,
   output logic                   AXIS_TX_TLAST,
   input  logic                   AXIS_TX_TREADY,
   output logic [31:0]            SEQ_NUM,
   output logic                   LEN_ERR,
   output logic [15:0]            LEN_ERR_COUNT
);

   localparam logic [STREAM_WB-1:0] HDR_KEEP =
      {{(STREAM_WB-RDMA_HDR_LEN){1'b0}}, {RDMA_HDR_LEN{1'b1}}};

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t                r_state;
   logic [63:0]           r_addr;
   logic [31:0]           r_len;
   logic [USER_WB*8-1:0]  r_user;
   logic [31:0]           r_seq;
   logic [31:0]           r_byte_cnt;
   logic                  r_len_err;
   logic [15:0]           r_err_cnt;

   logic                  w_cmd_acc;
   logic                  w_hdr_hs;
   logic                  w_rx_hs;
   logic [31:0]           w_cnt_next;

   // Command is only taken once its first payload beat is already waiting,
   // so the header is never emitted ahead of a stalled payload source.
   // Handshake outputs are held low while reset is asserted.
   assign w_cmd_acc  = resetn & (r_state == IDLE) & CMD_VALID & AXIS_RX_TVALID;
   assign w_hdr_hs   = resetn & (r_state == HDR) & AXIS_TX_TREADY;
   assign w_rx_hs    = resetn & (r_state == DATA) & AXIS_RX_TVALID & AXIS_TX_TREADY;
   assign w_cnt_next = r_byte_cnt + popcount(POPC_W'(AXIS_RX_TKEEP));

   assign CMD_READY     = w_cmd_acc;
   assign SEQ_NUM       = r_seq;
   assign LEN_ERR       = r_len_err;
   assign LEN_ERR_COUNT = r_err_cnt;

   // Output mux: header beat built from the latched command in HDR,
   // straight pass-through of the payload in DATA.
   always_comb begin
      AXIS_TX_TDATA  = '0;
      AXIS_TX_TKEEP  = '0;
      AXIS_TX_TLAST  = 1'b0;
      AXIS_TX_TVALID = 1'b0;
      AXIS_RX_TREADY = 1'b0;
      case (r_state)
         HDR: begin
            AXIS_TX_TDATA[ADDR_OFS*8 +: 64]         = r_addr;
            AXIS_TX_TDATA[LEN_OFS*8  +: 32]         = r_len;
            AXIS_TX_TDATA[SEQ_OFS*8  +: 32]         = r_seq;
            AXIS_TX_TDATA[USER_OFS*8 +: USER_WB*8]  = r_user;
            AXIS_TX_TKEEP  = HDR_KEEP;
            AXIS_TX_TVALID = resetn;
         end
         DATA: begin
            AXIS_TX_TDATA  = AXIS_RX_TDATA;
            AXIS_TX_TKEEP  = AXIS_RX_TKEEP;
            AXIS_TX_TLAST  = AXIS_RX_TLAST;
            AXIS_TX_TVALID = resetn & AXIS_RX_TVALID;
            AXIS_RX_TREADY = resetn & AXIS_TX_TREADY;
         end
         default: ;
      endcase
   end

   // Control state, sequence number and length checking
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_seq      <= '0;
         r_byte_cnt <= '0;
         r_len_err  <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_len_err <= 1'b0;
         case (r_state)
            IDLE: if (w_cmd_acc) r_state <= HDR;
            HDR: if (w_hdr_hs) begin
               r_seq      <= r_seq + 32'd1;
               r_byte_cnt <= '0;
               r_state    <= DATA;
            end
            DATA: if (w_rx_hs) begin
               r_byte_cnt <= w_cnt_next;
               if (AXIS_RX_TLAST) begin
                  r_state <= IDLE;
                  if (w_cnt_next != r_len) begin
                     r_len_err <= 1'b1;
                     r_err_cnt <= sat_inc16(r_err_cnt);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Latched command fields (hdr_reg); pure data, no reset needed
   always_ff @(posedge clk) begin
      if (w_cmd_acc) begin
         r_addr <= CMD_ADDR;
         r_len  <= CMD_LEN;
         r_user <= CMD_USER;
      end
   end

endmodule

// File: tb/tb_rdma_hdr_insert.sv
// ---------------------------------------------------------------------------
// tb_rdma_hdr_insert
// Directed self-checking bench for rdma_hdr_insert (STREAM_WB=64,
// RDMA_HDR_LEN=50). Inputs are driven on the falling edge and outputs are
// sampled 1 time unit later; handshakes complete on the following rising edge.
// ---------------------------------------------------------------------------
module tb_rdma_hdr_insert;

   localparam int SWB = 64;
   localparam int HL  = 50;
   localparam int UWB = HL - 16;
   localparam logic [63:0] HDR_KEEP_EXP = 64'h0003_FFFF_FFFF_FFFF;

   logic               clk = 1'b0;
   logic               resetn = 1'b0;
   logic [63:0]        CMD_ADDR = '0;
   logic [31:0]        CMD_LEN = '0;
   logic [UWB*8-1:0]   CMD_USER = '0;
   logic               CMD_VALID = 1'b0;
   logic               CMD_READY;
   logic [SWB*8-1:0]   AXIS_RX_TDATA = '0;
   logic [SWB-1:0]     AXIS_RX_TKEEP = '0;
   logic               AXIS_RX_TVALID = 1'b0;
   logic               AXIS_RX_TLAST = 1'b0;
   logic               AXIS_RX_TREADY;
   logic [SWB*8-1:0]   AXIS_TX_TDATA;
   logic [SWB-1:0]     AXIS_TX_TKEEP;
   logic               AXIS_TX_TVALID;
   logic               AXIS_TX_TLAST;
   logic               AXIS_TX_TREADY = 1'b0;
   logic [31:0]        SEQ_NUM;
   logic               LEN_ERR;
   logic [15:0]        LEN_ERR_COUNT;

   rdma_hdr_insert #(.STREAM_WB(SWB), .RDMA_HDR_LEN(HL)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .CMD_ADDR       (CMD_ADDR),
      .CMD_LEN        (CMD_LEN),
      .CMD_USER       (CMD_USER),
      .CMD_VALID      (CMD_VALID),
      .CMD_READY      (CMD_READY),
      .AXIS_RX_TDATA  (AXIS_RX_TDATA),
      .AXIS_RX_TKEEP  (AXIS_RX_TKEEP),
      .AXIS_RX_TVALID (AXIS_RX_TVALID),
      .AXIS_RX_TLAST  (AXIS_RX_TLAST),
      .AXIS_RX_TREADY (AXIS_RX_TREADY),
      .AXIS_TX_TDATA  (AXIS_TX_TDATA),
      .AXIS_TX_TKEEP  (AXIS_TX_TKEEP),
      .AXIS_TX_TVALID (AXIS_TX_TVALID),
      .AXIS_TX_TLAST  (AXIS_TX_TLAST),
      .AXIS_TX_TREADY (AXIS_TX_TREADY),
      .SEQ_NUM        (SEQ_NUM),
      .LEN_ERR        (LEN_ERR),
      .LEN_ERR_COUNT  (LEN_ERR_COUNT)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference header: byte-by-byte little-endian layout
   function automatic logic [511:0] exp_hdr(input logic [63:0] a, input logic [31:0] l,
                                            input logic [31:0] s, input logic [UWB*8-1:0] u);
      logic [511:0] h;
      h = '0;
      for (int b = 0; b < HL; b++) begin
         if (b < 8)       h[8*b +: 8] = a[8*b +: 8];
         else if (b < 12) h[8*b +: 8] = l[8*(b-8) +: 8];
         else if (b < 16) h[8*b +: 8] = s[8*(b-12) +: 8];
         else             h[8*b +: 8] = u[8*(b-16) +: 8];
      end
      return h;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      CMD_VALID = 1'b0;
      AXIS_RX_TVALID = 1'b0;
      AXIS_RX_TLAST = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // One command + payload packet; checks every TX beat and the LEN_ERR pulse.
   task automatic run_pkt(input string tag, input logic [63:0] addr, input logic [31:0] len,
                          input logic [UWB*8-1:0] user, input int nbeats, input int last_bytes,
                          input bit rnd, input logic [31:0] seq, input bit exp_err,
                          output logic [511:0] hdr_d, output logic [63:0] hdr_k);
      logic [511:0] pd [8];
      logic [63:0]  lk;
      logic [63:0]  bk;
      logic [639:0] exp_beat;
      int rx_i, tx_i, cyc;
      bit cmd_done;
      lk = (last_bytes >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << last_bytes) - 64'd1);
      for (int i = 0; i < nbeats; i++)
         for (int j = 0; j < 16; j++) pd[i][j*32 +: 32] = $urandom();
      hdr_d = '0; hdr_k = '0;
      rx_i = 0; tx_i = 0; cyc = 0; cmd_done = 1'b0;
      while (tx_i <= nbeats && cyc < 100) begin
         @(negedge clk);
         CMD_VALID      = !cmd_done;
         CMD_ADDR       = addr;
         CMD_LEN        = len;
         CMD_USER       = user;
         AXIS_RX_TVALID = (rx_i < nbeats);
         AXIS_RX_TDATA  = pd[(rx_i < nbeats) ? rx_i : 0];
         AXIS_RX_TKEEP  = (rx_i == nbeats-1) ? lk : 64'hFFFF_FFFF_FFFF_FFFF;
         AXIS_RX_TLAST  = (rx_i == nbeats-1);
         AXIS_TX_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (CMD_VALID && CMD_READY) cmd_done = 1'b1;
         if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
            if (tx_i == 0) begin
               exp_beat = {1'b0, HDR_KEEP_EXP, exp_hdr(addr, len, seq, user)};
               hdr_d = AXIS_TX_TDATA;
               hdr_k = AXIS_TX_TKEEP;
            end else begin
               bk = (tx_i == nbeats) ? lk : 64'hFFFF_FFFF_FFFF_FFFF;
               exp_beat = {(tx_i == nbeats), bk, pd[tx_i-1]};
            end
            check($sformatf("%s_beat%0d", tag, tx_i),
                  {AXIS_TX_TLAST, AXIS_TX_TKEEP, AXIS_TX_TDATA}, exp_beat);
            tx_i++;
         end
         if (AXIS_RX_TVALID && AXIS_RX_TREADY) rx_i++;
         cyc++;
      end
      if (cyc >= 100) check({tag, "_timeout"}, tx_i, nbeats + 1);
      @(negedge clk);
      CMD_VALID = 1'b0;
      AXIS_RX_TVALID = 1'b0;
      AXIS_RX_TLAST = 1'b0;
      AXIS_TX_TREADY = 1'b1;
      #1;
      check({tag, "_len_err"}, LEN_ERR, exp_err);
      check({tag, "_idle_tvalid"}, AXIS_TX_TVALID, 1'b0);
   endtask

   logic [UWB*8-1:0] user;
   logic [511:0]     hd;
   logic [63:0]      hk;
   logic [31:0]      seq_m;
   int               nb, lb;

   initial begin
      for (int i = 0; i < UWB; i++) user[8*i +: 8] = 8'(i + 1);

      // Reset state, with command and payload offered during reset
      CMD_VALID = 1'b1;
      AXIS_RX_TVALID = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_seq", SEQ_NUM, 32'd0);
      check("rst_len_err", LEN_ERR, 1'b0);
      check("rst_err_cnt", LEN_ERR_COUNT, 16'd0);
      check("rst_cmd_ready", CMD_READY, 1'b0);
      check("rst_tx_tvalid", AXIS_TX_TVALID, 1'b0);
      check("rst_rx_tready", AXIS_RX_TREADY, 1'b0);
      CMD_VALID = 1'b0;
      AXIS_RX_TVALID = 1'b0;
      resetn = 1'b1;

      // Basic two-beat packet with hand-computed header fields
      run_pkt("t2", 64'h1122334455667788, 32'd128, user, 2, 64, 1'b0, 32'd0, 1'b0, hd, hk);
      check("t2_byte0", hd[7:0], 8'h88);
      check("t2_addr", hd[63:0], 64'h1122334455667788);
      check("t2_len", hd[95:64], 32'd128);
      check("t2_seq", hd[127:96], 32'd0);
      check("t2_user_b16", hd[135:128], 8'h01);
      check("t2_user_b49", hd[399:392], 8'h22);
      check("t2_upper_zero", hd[511:400], 112'd0);
      check("t2_keep", hk, 64'h0003_FFFF_FFFF_FFFF);
      check("t2_seq_num", SEQ_NUM, 32'd1);
      check("t2_err_cnt", LEN_ERR_COUNT, 16'd0);

      // Partial last beat: 64 + 6 = 70 bytes
      run_pkt("t3a", 64'h0, 32'd70, user, 2, 6, 1'b0, 32'd1, 1'b0, hd, hk);
      run_pkt("t3b", 64'h0, 32'd71, user, 2, 6, 1'b0, 32'd2, 1'b1, hd, hk);
      check("t3_err_cnt", LEN_ERR_COUNT, 16'd1);
      @(negedge clk);
      #1;
      check("t3_err_pulse_once", LEN_ERR, 1'b0);

      // Reset in the middle of a payload (3 beats forwarded)
      @(negedge clk);
      CMD_VALID = 1'b1; CMD_ADDR = 64'hA; CMD_LEN = 32'd320; CMD_USER = user;
      AXIS_RX_TVALID = 1'b1; AXIS_RX_TKEEP = '1; AXIS_RX_TLAST = 1'b0;
      AXIS_RX_TDATA = 512'h100; AXIS_TX_TREADY = 1'b1;
      @(negedge clk);
      CMD_VALID = 1'b0;
      #1;
      check("t1_hdr_valid", AXIS_TX_TVALID, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         AXIS_RX_TDATA = 512'h100 + 512'(i);
         #1;
         check($sformatf("t1_pass%0d", i), {AXIS_TX_TVALID, AXIS_TX_TDATA}, {1'b1, 512'h100 + 512'(i)});
      end
      check("t1_seq_before", SEQ_NUM, 32'd4);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("t1_tvalid_in_reset", AXIS_TX_TVALID, 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check("t1_tvalid_after", AXIS_TX_TVALID, 1'b0);
      check("t1_seq_after", SEQ_NUM, 32'd0);
      check("t1_err_cnt_after", LEN_ERR_COUNT, 16'd0);
      AXIS_RX_TVALID = 1'b0;
      run_pkt("t1_next", 64'hCAFE, 32'd64, user, 1, 64, 1'b0, 32'd0, 1'b0, hd, hk);

      // Command waiting without payload, then payload arrives
      @(negedge clk);
      CMD_VALID = 1'b1; CMD_ADDR = 64'hDEAD_BEEF; CMD_LEN = 32'd8; CMD_USER = user;
      AXIS_RX_TVALID = 1'b0; AXIS_TX_TREADY = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("t5_wait%0d", i), {CMD_READY, AXIS_TX_TVALID}, 2'b00);
         @(negedge clk);
      end
      AXIS_RX_TVALID = 1'b1; AXIS_RX_TDATA = 512'hABCD; AXIS_RX_TKEEP = 64'hFF; AXIS_RX_TLAST = 1'b1;
      #1;
      check("t5_cmd_ready", CMD_READY, 1'b1);
      @(negedge clk);
      CMD_VALID = 1'b0;
      #1;
      check("t5_hdr", {AXIS_TX_TVALID, AXIS_TX_TDATA},
            {1'b1, exp_hdr(64'hDEAD_BEEF, 32'd8, 32'd1, user)});
      @(negedge clk);
      #1;
      check("t5_beat", {AXIS_TX_TVALID, AXIS_TX_TLAST, AXIS_TX_TKEEP, AXIS_TX_TDATA},
            {1'b1, 1'b1, 64'hFF, 512'hABCD});
      @(negedge clk);
      AXIS_RX_TVALID = 1'b0; AXIS_RX_TLAST = 1'b0;
      #1;
      check("t5_len_err", LEN_ERR, 1'b0);
      check("t5_seq", SEQ_NUM, 32'd2);

      // 100 packets with random downstream backpressure
      do_reset();
      seq_m = 32'd0;
      for (int p = 0; p < 100; p++) begin
         nb = $urandom_range(1, 4);
         lb = $urandom_range(1, 64);
         run_pkt($sformatf("t4p%0d", p), {32'h5000_0000, 32'(p)}, 32'(64*(nb-1) + lb), user,
                 nb, lb, 1'b1, seq_m, 1'b0, hd, hk);
         seq_m = seq_m + 32'd1;
      end
      check("t4_seq", SEQ_NUM, 32'd100);
      check("t4_err_cnt", LEN_ERR_COUNT, 16'd0);

      // Sequence number wrap
      @(negedge clk);
      force dut.r_seq = 32'hFFFF_FFFF;
      #1;
      release dut.r_seq;
      #1;
      check("t6_seq_preset", SEQ_NUM, 32'hFFFF_FFFF);
      run_pkt("t6", 64'h77, 32'd16, user, 1, 16, 1'b0, 32'hFFFF_FFFF, 1'b0, hd, hk);
      check("t6_seq_wrap", SEQ_NUM, 32'd0);

      // Zero length always flags; error counter saturates
      @(negedge clk);
      force dut.r_err_cnt = 16'hFFFE;
      #1;
      release dut.r_err_cnt;
      run_pkt("t7a", 64'h1, 32'd0, user, 1, 4, 1'b0, 32'd0, 1'b1, hd, hk);
      check("t7_cnt_max", LEN_ERR_COUNT, 16'hFFFF);
      run_pkt("t7b", 64'h2, 32'd0, user, 1, 4, 1'b0, 32'd1, 1'b1, hd, hk);
      check("t7_cnt_sat", LEN_ERR_COUNT, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
